act_skew_feeder: RTL and testbench

Downstream stage of the sequential router. Accepts the 64-bit activation words the router emits for each convolution window, buffers them in a small FIFO, and drives the PE array's byte lanes with the diagonal skew it expects: lane r lags lane 0 by r cycles. It counts words per window and signals window completion once the last lane has carried the last word.

---
 rtl/act_skew_feeder.sv | 156 +++++++++++++++
 tb/tb_act_skew_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: buffers router words in a FIFO and drives the PE byte lanes with a diagonal skew.
// Optional FEEDER_ZERO_GATE_EN forces an invalid lane's byte to zero.
module act_skew_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_reg_clear,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_ready,
  input  logic [ADDR_WIDTH-1:0]   i_route_size,
  input  logic                    i_pe_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_valid,
  output logic                    o_busy,
  output logic                    o_window_done
);

  localparam int ROWS = DATA_WIDTH / 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int DW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t                  r_state, w_state_n;
  logic [ADDR_WIDTH-1:0]   r_len, w_len_n;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_n;
  logic [DW-1:0]           r_dcnt, w_dcnt_n;
  logic                    r_done, w_done_n;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [PW:0]             r_wr_ptr, r_rd_ptr;
  logic                    w_flush, w_full, w_empty, w_push, w_pop;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [ROWS-1:0]         w_lane_vld;
  logic [DATA_WIDTH-1:0]   w_lane_byte;

  assign w_flush   = i_rst | i_reg_clear;
  assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_ready   = !w_full && !i_rst;
  assign w_push    = i_valid && o_ready;
  assign w_pop     = (r_state == S_STREAM) && !w_empty && i_pe_ready;
  assign w_rd_data = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_len   <= w_len_n;
      r_cnt   <= w_cnt_n;
      r_dcnt  <= w_dcnt_n;
      r_done  <= w_done_n;
    end
  end

  // The done pulse is registered so it lines up with lane ROWS-1 showing the last word;
  // DRAIN then lingers one cycle at dcnt==0, keeping two windows apart in the skew.
  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_cnt_n   = r_cnt;
    w_dcnt_n  = r_dcnt;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (i_route_size != '0)) begin
          w_state_n = S_STREAM;
          w_len_n   = i_route_size;
          w_cnt_n   = '0;
        end
      end
      S_STREAM: begin
        if (w_pop) begin
          w_cnt_n = r_cnt + 1'b1;
          if (w_cnt_n == r_len) begin
            w_state_n = S_DRAIN;
            w_dcnt_n  = DRAIN_LOAD;
            w_done_n  = (ROWS == 1);
          end
        end
      end
      S_DRAIN: begin
        if (r_dcnt == '0) begin
          w_state_n = S_IDLE;
        end else if (i_pe_ready) begin
          w_dcnt_n = r_dcnt - 1'b1;
          w_done_n = (r_dcnt == DW'(1));
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Lane r is an (r+1)-deep chain; the head byte holds its last popped value across bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0] r_vld;
    logic [7:0] r_byte [r+1];

    always_ff @(posedge i_clk) begin
      if (w_flush) begin
        r_vld <= '0;
        for (int s = 0; s <= r; s++) r_byte[s] <= 8'h00;
      end else if (i_pe_ready) begin
        r_vld[0] <= w_pop;
        if (w_pop) r_byte[0] <= w_rd_data[8*r +: 8];
        for (int s = 1; s <= r; s++) begin
          r_vld[s]  <= r_vld[s-1];
          r_byte[s] <= r_byte[s-1];
        end
      end
    end

    assign w_lane_vld[r] = r_vld[r];
`ifdef FEEDER_ZERO_GATE_EN
    assign w_lane_byte[8*r +: 8] = r_vld[r] ? r_byte[r] : 8'h00;
`else
    assign w_lane_byte[8*r +: 8] = r_byte[r];
`endif
  end

  assign o_data        = w_lane_byte;
  assign o_valid       = w_lane_vld;
  assign o_busy        = (r_state != S_IDLE);
  assign o_window_done = r_done;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Testbench for act_skew_feeder (default 64-bit, 8-lane, 8-deep configuration).
module tb_act_skew_feeder;

  localparam int ROWS  = 8;
  localparam int DEPTH = 8;
`ifdef FEEDER_ZERO_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clr, inValid, peReady;
  logic [63:0] inData;
  logic [7:0]  routeSize;
  logic        oReady, oBusy, oDone;
  logic [63:0] oData;
  logic [7:0]  oValid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  act_skew_feeder #(.DATA_WIDTH(64), .DEPTH(DEPTH), .ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_reg_clear(clr), .i_valid(inValid), .i_data(inData),
    .o_ready(oReady), .i_route_size(routeSize), .i_pe_ready(peReady),
    .o_data(oData), .o_valid(oValid), .o_busy(oBusy), .o_window_done(oDone)
  );

  // Reference: window phases (0 idle, 1 stream, 2 drain, 3 done cycle), a word queue,
  // and a history of what the lane-0 head held after each advance.
  int          mPhase = 0, mLeft = 0, mNeed = 0;
  logic [63:0] mFifo[$];
  logic        mHistV [ROWS];
  logic [63:0] mHistW [ROWS];
  logic        mDone = 1'b0;
  logic        mPop, mPush;

  always @(posedge clk) begin
    if (rst || clr) begin
      mFifo.delete();
      mPhase = 0;
      mDone  = 1'b0;
      for (int i = 0; i < ROWS; i++) begin mHistV[i] = 1'b0; mHistW[i] = 64'h0; end
    end else begin
      mPop  = (mPhase == 1) && (mFifo.size() > 0) && peReady;
      mPush = inValid && (mFifo.size() < DEPTH);
      mDone = 1'b0;
      case (mPhase)
        0: if (mFifo.size() > 0 && routeSize != 8'd0) begin mPhase = 1; mLeft = int'(routeSize); end
        1: if (mPop) begin
             mLeft = mLeft - 1;
             if (mLeft == 0) begin mPhase = 2; mNeed = ROWS - 1; end
           end
        2: if (peReady) begin
             mNeed = mNeed - 1;
             if (mNeed == 0) begin mPhase = 3; mDone = 1'b1; end
           end
        default: mPhase = 0;
      endcase
      if (peReady) begin
        for (int i = ROWS - 1; i > 0; i--) begin mHistV[i] = mHistV[i-1]; mHistW[i] = mHistW[i-1]; end
        mHistV[0] = mPop;
        if (mPop) mHistW[0] = mFifo[0];
      end
      if (mPop) void'(mFifo.pop_front());
      if (mPush) mFifo.push_back(inData);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) nextCycle();
    checks++;
    if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_low: got %b expected 0", oReady); end
    rst = 1'b0;
    nextCycle();
    checks++;
    if (oValid !== 8'h00) begin errors++; $display("[TB] FAIL reset_valid: got %h expected 00", oValid); end
    checks++;
    if (oData !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", oData); end
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", oBusy); end
    checks++;
    if (oDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", oDone); end
    checks++;
    if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", oReady); end
  endtask

  task automatic test_single_word();
    logic [7:0] ev;
    int         r;
    routeSize = 8'd1;
    inData    = 64'h0807060504030201;
    inValid   = 1'b1;
    nextCycle();
    inValid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      ev = (i >= 3 && i <= 10) ? (8'd1 << (i - 3)) : 8'd0;
      checks++;
      if (oValid !== ev) begin errors++; $display("[TB] FAIL single_valid@%0d: got %h expected %h", i, oValid, ev); end
      if (i >= 3 && i <= 10) begin
        r = i - 3;
        checks++;
        if (oData[8*r +: 8] !== 8'(r + 1))
          begin errors++; $display("[TB] FAIL single_lane%0d_byte: got %h expected %h", r, oData[8*r +: 8], 8'(r + 1)); end
      end
      if (i == 4) begin
        checks++;
        if (oData[7:0] !== (GATED ? 8'h00 : 8'h01))
          begin errors++; $display("[TB] FAIL bubble_byte0: got %h expected %h", oData[7:0], GATED ? 8'h00 : 8'h01); end
      end
      checks++;
      if (oDone !== (i == 10)) begin errors++; $display("[TB] FAIL single_done@%0d: got %b expected %b", i, oDone, i == 10); end
      checks++;
      if (oBusy !== (i >= 2 && i <= 10)) begin errors++; $display("[TB] FAIL single_busy@%0d: got %b expected %b", i, oBusy, (i >= 2 && i <= 10)); end
      nextCycle();
    end
  endtask

  task automatic test_long_window();
    logic [63:0] w [9];
    int seen = 0, doneCnt = 0, off;
    for (int k = 0; k < 9; k++) w[k] = {$urandom, $urandom};
    routeSize = 8'd9;
    for (int i = 0; i < 24; i++) begin
      inValid = (i < 9);
      inData  = (i < 9) ? w[i] : 64'h0;
      nextCycle();
      off = i + 1;
      if (oValid[0]) begin
        checks++;
        if (seen >= 9) begin errors++; $display("[TB] FAIL long_extra_pop: got word %0d expected at most 9", seen + 1); end
        else if (oData[7:0] !== w[seen][7:0])
          begin errors++; $display("[TB] FAIL long_lane0_byte%0d: got %h expected %h", seen, oData[7:0], w[seen][7:0]); end
        seen++;
      end
      if (oDone) doneCnt++;
      if (off == 18) begin
        checks++;
        if (oDone !== 1'b1 || oValid[7] !== 1'b1 || oBusy !== 1'b1)
          begin errors++; $display("[TB] FAIL long_done_cycle: got done=%b v7=%b busy=%b expected 1 1 1", oDone, oValid[7], oBusy); end
      end
      if (off == 19) begin
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL long_busy_fall: got %b expected 0", oBusy); end
      end
    end
    inValid = 1'b0;
    checks++;
    if (seen != 9) begin errors++; $display("[TB] FAIL long_pop_count: got %0d expected 9", seen); end
    checks++;
    if (doneCnt != 1) begin errors++; $display("[TB] FAIL long_done_count: got %0d expected 1", doneCnt); end
  endtask

  task automatic test_backpressure();
    logic [63:0] w [9];
    int seen = 0, doneCnt = 0, doneOff = -1, off;
    for (int k = 0; k < 9; k++) w[k] = {$urandom, $urandom};
    for (int i = 0; i < 28; i++) begin
      inValid   = (i < 9);
      inData    = (i < 9) ? w[i] : 64'h0;
      routeSize = (i >= 9) ? 8'd8 : 8'd0;
      if (i <= 9) begin
        checks++;
        if (oReady !== (i < 8)) begin errors++; $display("[TB] FAIL bp_ready@%0d: got %b expected %b", i, oReady, i < 8); end
      end
      nextCycle();
      off = i + 1;
      if (oValid[0]) begin
        checks++;
        if (seen >= 8) begin errors++; $display("[TB] FAIL bp_extra_word: got word %0d expected at most 8", seen + 1); end
        else if (oData[7:0] !== w[seen][7:0])
          begin errors++; $display("[TB] FAIL bp_lane0_byte%0d: got %h expected %h", seen, oData[7:0], w[seen][7:0]); end
        seen++;
      end
      if (oDone) begin doneCnt++; doneOff = off; end
    end
    inValid = 1'b0;
    checks++;
    if (seen != 8) begin errors++; $display("[TB] FAIL bp_word_count: got %0d expected 8", seen); end
    checks++;
    if (doneCnt != 1 || doneOff != 25) begin errors++; $display("[TB] FAIL bp_done: got count=%0d at %0d expected 1 at 25", doneCnt, doneOff); end
  endtask

  task automatic test_stall();
    logic [63:0] w [6];
    int doneCnt = 0, doneOff = -1, off;
    for (int k = 0; k < 6; k++) w[k] = {$urandom, $urandom};
    routeSize = 8'd6;
    for (int i = 0; i < 22; i++) begin
      inValid = (i < 6);
      inData  = (i < 6) ? w[i] : 64'h0;
      peReady = !(i >= 4 && i <= 6);
      nextCycle();
      off = i + 1;
      if (off >= 4 && off <= 7) begin
        checks++;
        if (oValid !== 8'h03 || oData[7:0] !== w[1][7:0] || oData[15:8] !== w[0][15:8])
          begin errors++; $display("[TB] FAIL stall_freeze@%0d: got v=%h b0=%h b1=%h expected 03 %h %h",
                                   off, oValid, oData[7:0], oData[15:8], w[1][7:0], w[0][15:8]); end
      end
      if (oDone) begin doneCnt++; doneOff = off; end
    end
    inValid = 1'b0;
    peReady = 1'b1;
    checks++;
    if (doneCnt != 1 || doneOff != 18) begin errors++; $display("[TB] FAIL stall_done: got count=%0d at %0d expected 1 at 18", doneCnt, doneOff); end
  endtask

  task automatic test_clear_drain();
    int doneCnt = 0, off;
    routeSize = 8'd4;
    for (int i = 0; i < 20; i++) begin
      inValid = (i < 4);
      inData  = {$urandom, $urandom};
      clr     = (i == 8);
      nextCycle();
      off = i + 1;
      if (off == 8) begin
        checks++;
        if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL clear_pre_busy: got %b expected 1", oBusy); end
      end
      if (off == 9) begin
        checks++;
        if (oValid !== 8'h00 || oBusy !== 1'b0 || oReady !== 1'b1 || oData !== 64'h0)
          begin errors++; $display("[TB] FAIL clear_state: got v=%h busy=%b ready=%b data=%h expected 00 0 1 0",
                                   oValid, oBusy, oReady, oData); end
      end
      if (oDone) doneCnt++;
    end
    clr = 1'b0;
    inValid = 1'b0;
    checks++;
    if (doneCnt != 0) begin errors++; $display("[TB] FAIL clear_no_done: got %0d expected 0", doneCnt); end
  endtask

  task automatic test_random();
    logic [7:0]  expV;
    logic [63:0] expD;
    logic        expReady;
    for (int i = 0; i < 900; i++) begin
      if (i < 820) begin
        inValid   = 1'($urandom_range(0, 1));
        inData    = {$urandom, $urandom};
        routeSize = 8'($urandom_range(0, 5));
        peReady   = ($urandom_range(0, 7) != 0);
        clr       = ($urandom_range(0, 149) == 0);
      end else begin
        inValid   = 1'b0;
        routeSize = 8'd3;
        peReady   = 1'b1;
        clr       = 1'b0;
      end
      nextCycle();
      for (int r = 0; r < ROWS; r++) begin
        expV[r]        = mHistV[r];
        expD[8*r +: 8] = (mHistV[r] || !GATED) ? mHistW[r][8*r +: 8] : 8'h00;
      end
      expReady = (mFifo.size() < DEPTH) && !rst;
      checks++;
      if (oValid !== expV) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %h expected %h", i, oValid, expV); end
      checks++;
      if (oData !== expD) begin errors++; $display("[TB] FAIL rand_data@%0d: got %h expected %h", i, oData, expD); end
      checks++;
      if (oDone !== mDone) begin errors++; $display("[TB] FAIL rand_done@%0d: got %b expected %b", i, oDone, mDone); end
      checks++;
      if (oBusy !== (mPhase != 0)) begin errors++; $display("[TB] FAIL rand_busy@%0d: got %b expected %b", i, oBusy, mPhase != 0); end
      checks++;
      if (oReady !== expReady) begin errors++; $display("[TB] FAIL rand_ready@%0d: got %b expected %b", i, oReady, expReady); end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; inValid = 1'b0; inData = 64'h0;
    routeSize = 8'd0; peReady = 1'b1;
    test_reset();
    test_single_word();
    test_long_window();
    test_backpressure();
    test_stall();
    test_clear_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
